// File: rtl/regbank_pkg.sv
// Shared register-bank definitions used by register_bank and operand_fetch.
//   AW   : register address width
//   DW   : register data width
//   NREG : number of architectural registers (2**AW)
package regbank_pkg;
  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int NREG = 1 << AW;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] reg_data_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard for operand_fetch.
// Tracks registers with an issued-but-not-written-back result and reports
// whether the presented instruction must stall.
//   clk, rst          : clock, synchronous active-high reset
//   src1, src2, dst   : register fields of the presented instruction
//   wr                : presented instruction writes dst
//   wb_en, wb_addr    : writeback snoop (clears busy)
//   set_en            : instruction accepted with a write (sets busy[dst])
//   hz                : RAW/WAW hazard on the presented instruction
module rf_scoreboard
  import regbank_pkg::*;
#(
  parameter int SB_AW   = AW,
  parameter int SB_NREG = NREG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SB_AW-1:0] src1,
  input  logic [SB_AW-1:0] src2,
  input  logic [SB_AW-1:0] dst,
  input  logic             wr,
  input  logic             wb_en,
  input  logic [SB_AW-1:0] wb_addr,
  input  logic             set_en,
  output logic             hz
);

  logic [SB_NREG-1:0] busy;
  logic [SB_NREG-1:0] busy_nxt;
  logic               clr1, clr2, clrd;

  // A writeback landing this cycle resolves the hazard: its data is
  // forwarded, so the lookup ignores a busy bit about to be cleared.
  always_comb begin
    clr1 = wb_en && (wb_addr == src1);
    clr2 = wb_en && (wb_addr == src2);
    clrd = wb_en && (wb_addr == dst);
    hz   = (busy[src1] && !clr1) ||
           (busy[src2] && !clr2) ||
           (wr && busy[dst] && !clrd);
  end

  // Set is applied after clear so a same-cycle set/clear leaves it busy.
  always_comb begin
    busy_nxt = busy;
    if (wb_en)  busy_nxt[wb_addr] = 1'b0;
    if (set_en) busy_nxt[dst]     = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage between decode and execute.
// Drives the register bank read selects, forwards same-cycle writeback
// data, stalls on scoreboard hazards and holds operands in an output
// register with valid/ready handshake.
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready             : decode handshake
//   in_src1/in_src2/in_dst/in_wr  : decoded instruction fields
//   rb_src1/rb_src2               : bank read selects
//   rb_dout1/rb_dout2             : bank combinational read data
//   wb_en/wb_addr/wb_data         : writeback snoop (bank write port)
//   out_valid/out_ready           : execute handshake
//   out_op1/out_op2/out_dst/out_wr: registered operands to execute
module operand_fetch
  import regbank_pkg::*;
#(
  parameter int OF_AW   = AW,
  parameter int OF_DW   = DW,
  parameter int OF_NREG = NREG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OF_AW-1:0] in_src1,
  input  logic [OF_AW-1:0] in_src2,
  input  logic [OF_AW-1:0] in_dst,
  input  logic             in_wr,
  output logic [OF_AW-1:0] rb_src1,
  output logic [OF_AW-1:0] rb_src2,
  input  logic [OF_DW-1:0] rb_dout1,
  input  logic [OF_DW-1:0] rb_dout2,
  input  logic             wb_en,
  input  logic [OF_AW-1:0] wb_addr,
  input  logic [OF_DW-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OF_DW-1:0] out_op1,
  output logic [OF_DW-1:0] out_op2,
  output logic [OF_AW-1:0] out_dst,
  output logic             out_wr
);

  logic             hz;
  logic             accept;
  logic [OF_DW-1:0] op1, op2;

  assign rb_src1 = in_src1;
  assign rb_src2 = in_src2;

  rf_scoreboard #(.SB_AW(OF_AW), .SB_NREG(OF_NREG)) u_sb (
    .clk     (clk),
    .rst     (rst),
    .src1    (in_src1),
    .src2    (in_src2),
    .dst     (in_dst),
    .wr      (in_wr),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .set_en  (accept && in_wr),
    .hz      (hz)
  );

  assign in_ready = !hz && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // The bank commits wb_data only at the next edge, so a same-cycle
  // writeback must bypass the bank read, busy or not.
  always_comb begin
    op1 = (wb_en && (wb_addr == in_src1)) ? wb_data : rb_dout1;
    op2 = (wb_en && (wb_addr == in_src2)) ? wb_data : rb_dout2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_op1   <= '0;
      out_op2   <= '0;
      out_dst   <= '0;
      out_wr    <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_op1   <= op1;
      out_op2   <= op2;
      out_dst   <= in_dst;
      out_wr    <= in_wr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: a behavioural register bank plus
// a reference model of issue/stall/forwarding, directed scenarios with
// literal expectations, then randomized traffic.
module tb_operand_fetch;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NREG = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_wr;
  logic [AW-1:0] in_src1, in_src2, in_dst;
  logic [AW-1:0] rb_src1, rb_src2;
  logic [DW-1:0] rb_dout1, rb_dout2;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          out_valid, out_ready, out_wr;
  logic [DW-1:0] out_op1, out_op2;
  logic [AW-1:0] out_dst;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_dst(in_dst), .in_wr(in_wr),
    .rb_src1(rb_src1), .rb_src2(rb_src2),
    .rb_dout1(rb_dout1), .rb_dout2(rb_dout2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_dst(out_dst), .out_wr(out_wr)
  );

  // Behavioural bank: combinational read, write at clock edge.
  logic [DW-1:0] bank [NREG];
  assign rb_dout1 = bank[rb_src1];
  assign rb_dout2 = bank[rb_src2];
  always @(posedge clk) if (wb_en) bank[wb_addr] <= wb_data;

  // Reference model state.
  bit            m_busy [NREG];
  bit            m_valid;
  logic [DW-1:0] m_op1, m_op2;
  logic [AW-1:0] m_dst;
  bit            m_wr;

  int n_chk = 0, n_fail = 0;
  bit seen_ready;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] r);
    // Value an instruction sees for r: pending writeback wins over the bank.
    if (wb_en && wb_addr == r) return wb_data;
    return bank[r];
  endfunction

  // One clock: compare mid-cycle, advance the model, step past the edge.
  task automatic cyc();
    bit stall, rdy, acc;
    #3;
    stall = (m_busy[in_src1] && !(wb_en && wb_addr == in_src1)) ||
            (m_busy[in_src2] && !(wb_en && wb_addr == in_src2)) ||
            (in_wr && m_busy[in_dst] && !(wb_en && wb_addr == in_dst));
    rdy = !stall && (!m_valid || out_ready);
    acc = in_valid && rdy && !rst;
    seen_ready = in_ready;
    chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    chk("rb_src1", {28'b0, rb_src1}, {28'b0, in_src1});
    chk("rb_src2", {28'b0, rb_src2}, {28'b0, in_src2});
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("out_op1", out_op1, m_op1);
      chk("out_op2", out_op2, m_op2);
      chk("out_dst", {28'b0, out_dst}, {28'b0, m_dst});
      chk("out_wr", {31'b0, out_wr}, {31'b0, m_wr});
    end
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_valid = 0;
    end else begin
      if (acc) begin
        m_valid = 1; m_op1 = rd(in_src1); m_op2 = rd(in_src2);
        m_dst = in_dst; m_wr = in_wr;
      end else if (out_ready) m_valid = 0;
      if (wb_en) m_busy[wb_addr] = 0;
      if (acc && in_wr) m_busy[in_dst] = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 0; in_src1 = 0; in_src2 = 0; in_dst = 0; in_wr = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 1;
  endtask

  task automatic issue(input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                       input logic [AW-1:0] d, input logic w);
    in_valid = 1; in_src1 = s1; in_src2 = s2; in_dst = d; in_wr = w;
  endtask

  task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] v);
    wb_en = 1; wb_addr = a; wb_data = v;
  endtask

  initial begin
    foreach (bank[i]) bank[i] = '0;
    idle(); rst = 1;
    @(posedge clk); #1;
    cyc(); cyc();
    rst = 0;
    cyc();
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);

    // Plain read of a previously written register.
    wb(1, 32'h42568399); cyc(); idle();
    issue(1, 0, 0, 0); cyc(); idle();
    chk("read op1", out_op1, 32'h42568399);
    chk("read op2", out_op2, 32'h0);
    chk("read valid", {31'b0, out_valid}, 32'd1);

    // Same-cycle forward.
    issue(2, 0, 0, 0); wb(2, 32'h002711a8); cyc();
    chk("fwd ready", {31'b0, seen_ready}, 32'd1);
    idle();
    chk("fwd op1", out_op1, 32'h002711a8);

    // RAW stall until writeback of r3.
    issue(0, 0, 3, 1); cyc();
    issue(0, 3, 0, 0); cyc();
    chk("raw stall", {31'b0, seen_ready}, 32'd0);
    cyc();
    chk("raw stall2", {31'b0, seen_ready}, 32'd0);
    wb(3, 32'h00022231); cyc();
    chk("raw release", {31'b0, seen_ready}, 32'd1);
    idle();
    chk("raw op2", out_op2, 32'h00022231);

    // Back-pressure: hold A (op1=r1) while B (op1=r2) waits.
    issue(1, 1, 6, 0); cyc();
    out_ready = 0; issue(2, 3, 7, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp ready", {31'b0, seen_ready}, 32'd0);
      chk("bp hold op1", out_op1, 32'h42568399);
      chk("bp hold dst", {28'b0, out_dst}, 32'd6);
    end
    out_ready = 1; cyc(); idle();
    chk("bp next op1", out_op1, 32'h002711a8);
    chk("bp next op2", out_op2, 32'h00022231);

    // Same-cycle set/clear on r5: set wins.
    issue(0, 0, 5, 1); cyc();
    issue(0, 0, 5, 1); wb(5, 32'h55); cyc(); idle();
    chk("setclr accept", {31'b0, seen_ready}, 32'd1);
    issue(5, 0, 0, 0); cyc();
    chk("r5 stall", {31'b0, seen_ready}, 32'd0);

    // Reset while stalled.
    rst = 1; cyc(); rst = 0;
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);
    cyc(); idle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      int nb;
      logic [AW-1:0] pick;
      rst = ($urandom_range(0, 299) == 0);
      in_valid = $urandom_range(0, 3) != 0;
      in_src1 = AW'($urandom); in_src2 = ($urandom_range(0, 5) == 0) ? in_src1 : AW'($urandom);
      in_dst = ($urandom_range(0, 5) == 0) ? in_src1 : AW'($urandom);
      in_wr = $urandom_range(0, 2) != 0;
      out_ready = $urandom_range(0, 9) < 7;
      nb = 0; pick = AW'($urandom);
      for (int r = 0; r < NREG; r++)
        if (m_busy[r] && $urandom_range(0, nb) == 0) begin pick = AW'(r); nb++; end
      wb_en = $urandom_range(0, 1);
      wb_addr = (nb > 0 && $urandom_range(0, 3) != 0) ? pick : AW'($urandom);
      wb_data = $urandom;
      cyc();
    end
    rst = 0; idle(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
